// File: rtl/buzzer_sequencer_if.sv
// Request/config/tone bus between the UI controller and buzzer_sequencer.
interface buzzer_sequencer_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TONE_W = 16,
    parameter int unsigned DUR_W  = 27,
    parameter int unsigned REP_W  = 4
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        req;
    logic                     cancel;
    logic [NUM_CH*TONE_W-1:0] cfg_half_period;
    logic [NUM_CH*DUR_W-1:0]  cfg_on_time;
    logic [NUM_CH*DUR_W-1:0]  cfg_off_time;
    logic [NUM_CH*REP_W-1:0]  cfg_repeat;
    logic                     buzzer;
    logic                     busy;
    logic [CH_W-1:0]          active_ch;
    logic                     done;

    modport master (
        output req, cancel, cfg_half_period, cfg_on_time, cfg_off_time, cfg_repeat,
        input  buzzer, busy, active_ch, done
    );

    modport slave (
        input  req, cancel, cfg_half_period, cfg_on_time, cfg_off_time, cfg_repeat,
        output buzzer, busy, active_ch, done
    );
endinterface

// File: rtl/buzzer_sequencer.sv
// Multi-channel fixed-priority beep sequencer driving a piezo square wave.
// Define BUZZER_PREEMPT_EN to let a higher-priority request abort the playing pattern.
module buzzer_sequencer #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TONE_W = 16,
    parameter int unsigned DUR_W  = 27,
    parameter int unsigned REP_W  = 4
) (
    input  logic clk,
    input  logic reset,
    buzzer_sequencer_if.slave bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} state_t;

    state_t             state;
    logic [NUM_CH-1:0]  pending;
    logic [TONE_W-1:0]  hp_q, tone_cnt;
    logic [DUR_W-1:0]   on_q, off_q, dur_cnt;
    logic [REP_W-1:0]   rep_q, burst_cnt;

    logic [NUM_CH-1:0]  cand_c;
    logic               win_vld_c;
    logic [CH_W-1:0]    win_idx_c;
    logic [TONE_W-1:0]  win_hp_c;
    logic [DUR_W-1:0]   win_on_c, win_off_c;
    logic [REP_W-1:0]   win_rep_c;
    logic               preempt_c;
    logic               grant_c;

    // Lowest-index candidate wins; its config is clamped before latching.
    always_comb begin
        cand_c    = pending | bus.req;
        win_vld_c = |cand_c;
        win_idx_c = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand_c[i]) win_idx_c = CH_W'(i);
        end
        win_hp_c  = bus.cfg_half_period[win_idx_c * TONE_W +: TONE_W];
        win_on_c  = bus.cfg_on_time[win_idx_c * DUR_W +: DUR_W];
        win_off_c = bus.cfg_off_time[win_idx_c * DUR_W +: DUR_W];
        win_rep_c = bus.cfg_repeat[win_idx_c * REP_W +: REP_W];
        if (win_hp_c < TONE_W'(2)) win_hp_c = TONE_W'(2);
        if (win_on_c == '0)        win_on_c = DUR_W'(1);
        if (win_rep_c == '0)       win_rep_c = REP_W'(1);
    end

`ifdef BUZZER_PREEMPT_EN
    assign preempt_c = (state != ST_IDLE) && win_vld_c && (win_idx_c < bus.active_ch);
`else
    assign preempt_c = 1'b0;
`endif

    assign grant_c = ((state == ST_IDLE) && win_vld_c) || preempt_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pending       <= '0;
            hp_q          <= '0;
            on_q          <= '0;
            off_q         <= '0;
            rep_q         <= '0;
            tone_cnt      <= '0;
            dur_cnt       <= '0;
            burst_cnt     <= '0;
            bus.buzzer    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.active_ch <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            pending  <= pending | bus.req;
            if (bus.cancel) begin
                state      <= ST_IDLE;
                pending    <= '0;
                tone_cnt   <= '0;
                dur_cnt    <= '0;
                burst_cnt  <= '0;
                bus.buzzer <= 1'b0;
                bus.busy   <= 1'b0;
            end else if (grant_c) begin
                // An aborted channel goes back into pending and restarts from burst 1.
                pending       <= (cand_c & ~(NUM_CH'(1) << win_idx_c))
                               | (preempt_c ? (NUM_CH'(1) << bus.active_ch) : '0);
                hp_q          <= win_hp_c;
                on_q          <= win_on_c;
                off_q         <= win_off_c;
                rep_q         <= win_rep_c;
                tone_cnt      <= '0;
                dur_cnt       <= '0;
                burst_cnt     <= REP_W'(1);
                state         <= ST_ON;
                bus.busy      <= 1'b1;
                bus.buzzer    <= 1'b0;
                bus.active_ch <= win_idx_c;
            end else begin
                case (state)
                    ST_ON: begin
                        if (tone_cnt == hp_q - TONE_W'(1)) begin
                            tone_cnt   <= '0;
                            bus.buzzer <= ~bus.buzzer;
                        end else begin
                            tone_cnt <= tone_cnt + TONE_W'(1);
                        end
                        if (dur_cnt == on_q - DUR_W'(1)) begin
                            dur_cnt    <= '0;
                            tone_cnt   <= '0;
                            bus.buzzer <= 1'b0;
                            if (burst_cnt < rep_q) begin
                                if (off_q == '0) burst_cnt <= burst_cnt + REP_W'(1);
                                else             state     <= ST_GAP;
                            end else begin
                                state    <= ST_IDLE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end
                    ST_GAP: begin
                        bus.buzzer <= 1'b0;
                        tone_cnt   <= '0;
                        if (dur_cnt == off_q - DUR_W'(1)) begin
                            dur_cnt   <= '0;
                            burst_cnt <= burst_cnt + REP_W'(1);
                            state     <= ST_ON;
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end
                    default: bus.buzzer <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed self-checking bench for buzzer_sequencer.
module tb_buzzer_sequencer;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned TONE_W = 16;
    localparam int unsigned DUR_W  = 27;
    localparam int unsigned REP_W  = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    buzzer_sequencer_if #(.NUM_CH(NUM_CH), .TONE_W(TONE_W), .DUR_W(DUR_W), .REP_W(REP_W)) bus_if ();

    buzzer_sequencer #(.NUM_CH(NUM_CH), .TONE_W(TONE_W), .DUR_W(DUR_W), .REP_W(REP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic set_cfg(input int ch, input int hp, input int on, input int off, input int rep);
        bus_if.cfg_half_period[ch*TONE_W +: TONE_W] = TONE_W'(hp);
        bus_if.cfg_on_time[ch*DUR_W +: DUR_W]       = DUR_W'(on);
        bus_if.cfg_off_time[ch*DUR_W +: DUR_W]      = DUR_W'(off);
        bus_if.cfg_repeat[ch*REP_W +: REP_W]        = REP_W'(rep);
    endtask

    // Leaves the bench at the first negedge after the grant edge (k = 0).
    task automatic pulse_req(input logic [NUM_CH-1:0] r);
        repeat (3) @(negedge clk);
        bus_if.req = r;
        @(negedge clk);
        bus_if.req = '0;
    endtask

    task automatic test_reset();
        logic [4:0] exp_v, got_v;
        reset = 1'b1;
        bus_if.req = '0;
        bus_if.cancel = 1'b0;
        bus_if.cfg_half_period = '0;
        bus_if.cfg_on_time = '0;
        bus_if.cfg_off_time = '0;
        bus_if.cfg_repeat = '0;
        repeat (3) @(negedge clk);
        got_v = {bus_if.buzzer, bus_if.busy, bus_if.active_ch, bus_if.done};
        n_cmp++;
        if (got_v !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", got_v, 5'b0);
        end
        reset = 1'b0;
        set_cfg(1, 2, 10, 0, 1);
        pulse_req(4'b0010);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus_if.buzzer !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_buzzer got=%b exp=1", bus_if.buzzer);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_v = 5'b0;
        got_v = {bus_if.buzzer, bus_if.busy, bus_if.active_ch, bus_if.done};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_pattern got=%b exp=%b", got_v, exp_v);
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp_v, got_v;
        logic eb;
        set_cfg(1, 4, 20, 10, 2);
        pulse_req(4'b0010);
        n_cmp++;
        if (bus_if.active_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_active_ch got=%0d exp=1", bus_if.active_ch);
        end
        for (int k = 0; k < 56; k++) begin
            if (k < 20)                 eb = ((k / 4) % 2) == 1;
            else if (k >= 30 && k < 50) eb = (((k - 30) / 4) % 2) == 1;
            else                        eb = 1'b0;
            exp_v = {eb, 1'(k < 50), 1'(k == 50)};
            got_v = {bus_if.buzzer, bus_if.busy, bus_if.done};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL basic_k%0d buz/busy/done got=%b exp=%b", k, got_v, exp_v);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus_if.active_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_active_hold got=%0d exp=1", bus_if.active_ch);
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_v, got_v;
        set_cfg(0, 2, 3, 0, 1);
        set_cfg(2, 2, 4, 0, 1);
        pulse_req(4'b0101);
        for (int k = 0; k < 14; k++) begin
            exp_v = {1'((k < 3) || (k >= 4 && k < 8)), 1'(k == 3 || k == 8),
                     (k < 4) ? 2'd0 : 2'd2};
            got_v = {bus_if.busy, bus_if.done, bus_if.active_ch};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL priority_k%0d busy/done/ch got=%b exp=%b", k, got_v, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pending_collapse();
        logic [3:0] exp_v, got_v;
        set_cfg(1, 2, 6, 2, 2);
        set_cfg(3, 2, 2, 0, 1);
        pulse_req(4'b0010);
        for (int k = 0; k < 24; k++) begin
            exp_v = {1'((k < 14) || (k >= 15 && k < 17)), 1'(k == 14 || k == 17),
                     (k < 15) ? 2'd1 : 2'd3};
            got_v = {bus_if.busy, bus_if.done, bus_if.active_ch};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL collapse_k%0d busy/done/ch got=%b exp=%b", k, got_v, exp_v);
            end
            bus_if.req = (k == 2 || k == 5 || k == 9) ? 4'b1000 : 4'b0000;
            @(negedge clk);
        end
        bus_if.req = '0;
    endtask

    task automatic test_cancel();
        logic [2:0] got_v;
        int pend;
`ifdef BUZZER_PREEMPT_EN
        pend = 3;
`else
        pend = 0;
`endif
        set_cfg(1, 4, 20, 0, 1);
        set_cfg(pend, 2, 2, 0, 1);
        pulse_req(4'b0010);
        for (int k = 0; k < 5; k++) begin
            bus_if.req = (k == 2) ? (NUM_CH'(1) << pend) : '0;
            @(negedge clk);
        end
        bus_if.req = '0;
        n_cmp++;
        if ({bus_if.buzzer, bus_if.busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL cancel_pre got=%b exp=11", {bus_if.buzzer, bus_if.busy});
        end
        bus_if.cancel = 1'b1;
        @(negedge clk);
        bus_if.cancel = 1'b0;
        for (int k = 0; k < 26; k++) begin
            got_v = {bus_if.buzzer, bus_if.busy, bus_if.done};
            n_cmp++;
            if (got_v !== 3'b000) begin
                n_fail++;
                $display("FAIL cancel_k%0d buz/busy/done got=%b exp=000", k, got_v);
            end
            @(negedge clk);
        end
        bus_if.cancel = 1'b1;
        bus_if.req = 4'b0100;
        @(negedge clk);
        bus_if.cancel = 1'b0;
        bus_if.req = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_if.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cancel_drops_req_k%0d busy got=%b exp=0", k, bus_if.busy);
            end
        end
    endtask

    task automatic test_clamp();
        logic [4:0] got_v, exp_v;
        set_cfg(2, 0, 0, 0, 0);
        pulse_req(4'b0100);
        for (int k = 0; k < 4; k++) begin
            exp_v = {1'b0, 1'(k == 0), 1'(k == 1), 2'd2};
            got_v = {bus_if.buzzer, bus_if.busy, bus_if.done, bus_if.active_ch};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL clamp_k%0d buz/busy/done/ch got=%b exp=%b", k, got_v, exp_v);
            end
            @(negedge clk);
        end
    endtask

`ifdef BUZZER_PREEMPT_EN
    task automatic test_preempt();
        logic [3:0] exp_v, got_v;
        logic [1:0] ech;
        set_cfg(2, 2, 4, 6, 2);
        set_cfg(0, 2, 2, 0, 1);
        pulse_req(4'b0100);
        for (int k = 0; k < 28; k++) begin
            ech = (k >= 6 && k < 9) ? 2'd0 : 2'd2;
            exp_v = {1'((k < 8) || (k >= 9 && k < 23)), 1'(k == 8 || k == 23), ech};
            got_v = {bus_if.busy, bus_if.done, bus_if.active_ch};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL preempt_k%0d busy/done/ch got=%b exp=%b", k, got_v, exp_v);
            end
            bus_if.req = (k == 5) ? 4'b0001 : 4'b0000;
            @(negedge clk);
        end
        bus_if.req = '0;
    endtask
`endif

    initial begin
        bus_if.req = '0;
        bus_if.cancel = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_pending_collapse();
        test_cancel();
        test_clamp();
`ifdef BUZZER_PREEMPT_EN
        test_preempt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_fail);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
Multi-channel, parametrised successor to the single-shot beep/alarm buzzer driver in the oven UI. It accepts NUM_CH independent beep requests (key click, door, completion, error, ...), arbitrates them by fixed priority and queues losers as pending. It then plays the granted channel's pattern as a repeated on/off tone burst with a runtime-programmable pitch, on-time, gap and repeat count. Its square-wave output drives the board piezo directly.

Parameters:
NUM_CH, 4, number of request channels; channel 0 has highest priority.
TONE_W, 16, width of the half-period field, in clk cycles.
DUR_W, 27, width of the on-time and gap fields, in clk cycles.
REP_W, 4, width of the repeat-count field.

Ports:
clk  in  1  system clock (100 MHz on board)
reset  in  1  synchronous, active-high reset
req  in  NUM_CH  per-channel request; a 1 in any cycle registers that channel
cancel  in  1  aborts the playing pattern and clears all pending requests
cfg_half_period  in  NUM_CH*TONE_W  per-channel tone half-period; channel i occupies bits [i*TONE_W +: TONE_W]
cfg_on_time  in  NUM_CH*DUR_W  per-channel tone-on duration
cfg_off_time  in  NUM_CH*DUR_W  per-channel silent gap between bursts
cfg_repeat  in  NUM_CH*REP_W  per-channel number of bursts
buzzer  out  1  registered square-wave output to the piezo
busy  out  1  high while any pattern is playing
active_ch  out  $clog2(NUM_CH) (minimum 1)  index of the channel being played; holds the last value when idle
done  out  1  one-cycle pulse when a pattern completes normally

Behaviour:
- Reset (synchronous, at a clk edge with reset=1): state IDLE, buzzer=0, busy=0, active_ch=0, done=0, pending=0, all counters 0. reset mid-pattern silences buzzer on the next edge.
- Pending register: pending[i] sets on req[i]=1. It clears when channel i is granted or on cancel. Repeated requests from a channel that is already pending collapse into one.
- States: IDLE, ON, GAP.
- IDLE: a channel is a candidate if pending|req is nonzero. The lowest-index candidate wins. At the next edge, the winner's config is latched, its pending bit is cleared, and state goes to ON with busy=1. A req seen at edge N gives busy=1 and active_ch valid after edge N.
- Latched config clamps: half_period<2 becomes 2; on_time=0 becomes 1; repeat=0 becomes 1. off_time=0 means GAP is skipped.
- ON: the tone counter counts 0..half_period-1. buzzer toggles on the wrap. buzzer starts at 0, so the first rising edge comes half_period cycles after entering ON. The duration counter runs on_time cycles.
  - If the burst count is below repeat: go to GAP.
  - On the last burst: go to IDLE, with done=1 for one cycle and busy=0.
- GAP: buzzer=0 and the tone counter is held at 0. After off_time cycles, go to ON and increment the burst count.
- buzzer is forced to 0 in IDLE and GAP.
- Completion always passes through at least one IDLE cycle before the next grant.
- Requests arriving while busy go to pending and do not disturb the current pattern (non-preempt build).
- cancel=1: state goes to IDLE, buzzer=0, busy=0, pending=0. done is not asserted. cancel takes priority over a simultaneous req, so that req is dropped.
- cfg_* is sampled only at grant; changing it mid-pattern has no effect.

Optional Feature:
BUZZER_PREEMPT_EN.
- Defined: in ON or GAP, a new req or pending entry with index below active_ch aborts the current pattern. The aborted channel is re-marked pending and restarts from burst 1 later. The winner is granted at the next edge, with the same latch and clamp rules as from IDLE. No done pulse is issued for the aborted pattern.
- Undefined: no preemption; the current pattern always runs to completion or cancel.

Test Plan:
1. Reset, then pulse req[1] with half_period=4, on=20, off=10, repeat=2 -> busy rises after 1 edge, active_ch=1. Expect two 20-cycle bursts of period 8 (first buzzer rise 4 cycles into ON), a 10-cycle silent gap between them, and done for exactly 1 cycle at the end.
2. Pulse req[2] and req[0] together while idle -> channel 0 plays first, channel 2 starts after done plus one idle cycle, and pending is 0 at the end.
3. Pulse req[3] three times during a channel-1 pattern (preempt undefined) -> channel 1 completes untouched, then channel 3 plays once.
4. Assert cancel mid-burst with req[0] pending -> buzzer=0 and busy=0 next cycle, no done pulse, channel 0 never plays.
5. Use channel config half_period=0, on=0, repeat=0 -> clamps apply: one 1-cycle burst, buzzer stays 0, done pulses.
6. With BUZZER_PREEMPT_EN defined, pulse req[0] during the channel-2 gap -> channel 0 granted next edge; after it finishes, channel 2 restarts from its first burst.
